// File: rtl/multi_clock_gen_if.sv
// Control/status bundle for multi_clock_gen.
// master: the block that issues start/stop and programs the channels.
// slave : the clock generator itself.
//   start, stop  - per-channel requests
//   half_period  - NUM_CH packed CNT_W fields, latched at start
//   burst_len    - NUM_CH packed BURST_W fields, latched at start (0 = free-run)
//   clk_out, rise_pulse, busy, done - registered per-channel status
interface multi_clock_gen_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
) ();

  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH*CNT_W-1:0]   half_period;
  logic [NUM_CH*BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]         clk_out;
  logic [NUM_CH-1:0]         rise_pulse;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;

  modport master (
    output start, stop, half_period, burst_len,
    input  clk_out, rise_pulse, busy, done
  );

  modport slave (
    input  start, stop, half_period, burst_len,
    output clk_out, rise_pulse, busy, done
  );

endinterface

// File: rtl/multi_clock_gen.sv
// Multi-channel divided clock generator.
// Each channel produces a 50% duty square wave of period 2*half_period clk
// cycles, either free-running (burst_len == 0) or for burst_len full cycles.
// A stop request ends the channel gracefully so clk_out always finishes low,
// followed by a one-cycle done strobe.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - multi_clock_gen_if.slave (requests, programming, status outputs)
module multi_clock_gen #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  multi_clock_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] done_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hp_q, hp_d;
    logic [CNT_W-1:0]   hp_in;
    logic [CNT_W-1:0]   cnt_step;
    logic [BURST_W-1:0] cyc_q, cyc_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] bl_in;
    logic [BURST_W:0]   cyc_inc;
    logic               clk_q, clk_d;
    logic               rise_q, rise_d;
    logic               done_q, done_d;
    logic               busy_q;
    logic               tgl;
    logic               last_cyc;
    logic               start_i;
    logic               stop_i;

    assign hp_in   = bus.half_period[i*CNT_W +: CNT_W];
    assign bl_in   = bus.burst_len[i*BURST_W +: BURST_W];
    assign start_i = bus.start[i];
    assign stop_i  = bus.stop[i];

    // Half-period boundary: the output toggles on this edge.
    assign tgl      = (cnt_q == (hp_q - CNT_W'(1)));
    assign cnt_step = tgl ? '0 : (cnt_q + CNT_W'(1));

    // Widened compare so burst_len = 2^BURST_W-1 terminates correctly.
    assign cyc_inc  = {1'b0, cyc_q} + (BURST_W + 1)'(1);
    assign last_cyc = (burst_q != '0) && (cyc_inc == {1'b0, burst_q});

    // State and datapath registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        cyc_q   <= '0;
        hp_q    <= CNT_W'(1);
        burst_q <= '0;
        clk_q   <= 1'b0;
        rise_q  <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cyc_q   <= cyc_d;
        hp_q    <= hp_d;
        burst_q <= burst_d;
        clk_q   <= clk_d;
        rise_q  <= rise_d;
        done_q  <= done_d;
        busy_q  <= (state_d != S_IDLE);
      end
    end

    // Next-state and next-output logic.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      hp_d    = hp_q;
      burst_d = burst_q;
      clk_d   = clk_q;
      rise_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
        S_IDLE: begin
          clk_d = 1'b0;
          // stop wins over a simultaneous start
          if (start_i && !stop_i) begin
            hp_d    = (hp_in == '0) ? CNT_W'(1) : hp_in;
            burst_d = bl_in;
            cnt_d   = '0;
            cyc_d   = '0;
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          cnt_d = cnt_step;
          if (stop_i && !clk_q) begin
            // Output already low: finish now, suppressing any pending rise.
            cnt_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (tgl) begin
            clk_d = !clk_q;
            if (!clk_q) begin
              rise_d = 1'b1;
            end else if (stop_i || last_cyc) begin
              // Falling edge coinciding with a stop or the burst end.
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              cyc_d = cyc_q + BURST_W'(1);
            end
          end else if (stop_i) begin
            state_d = S_STOP;
          end
        end

        S_STOP: begin
          cnt_d = cnt_step;
          if (tgl) begin
            clk_d = !clk_q;
            if (!clk_q) begin
              rise_d = 1'b1;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          clk_d   = 1'b0;
        end
      endcase
    end

    assign clk_out_v[i] = clk_q;
    assign rise_v[i]    = rise_q;
    assign busy_v[i]    = busy_q;
    assign done_v[i]    = done_q;

  end

  assign bus.clk_out    = clk_out_v;
  assign bus.rise_pulse = rise_v;
  assign bus.busy       = busy_v;
  assign bus.done       = done_v;

endmodule

// File: tb/tb_multi_clock_gen.sv
// Self-checking bench for multi_clock_gen: a cycle table for reset, burst,
// free-run/stop and ignored-request behaviour, plus hand-written sequences
// for long bursts, large half-periods, STOP-state drain and parallel channels.
module tb_multi_clock_gen;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BURST_W = 8;

  logic clk;
  logic rst;

  multi_clock_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  multi_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [15:0] hp;
    logic [7:0]  bl;
    logic [3:0]  e_clk;
    logic [3:0]  e_rise;
    logic [3:0]  e_busy;
    logic [3:0]  e_done;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic r, logic [3:0] st, logic [3:0] sp,
                              logic [15:0] hp, logic [7:0] bl,
                              logic [3:0] ec, logic [3:0] er,
                              logic [3:0] eb, logic [3:0] ed);
    vec_t v;
    v.rst = r;   v.start = st; v.stop = sp; v.hp = hp; v.bl = bl;
    v.e_clk = ec; v.e_rise = er; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s [%0d] got %0h expected %0h", name, idx, got, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] st, input logic [3:0] sp);
    rst       = r;
    bus.start = st;
    bus.stop  = sp;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] hp, input logic [7:0] bl);
    bus.half_period[ch*CNT_W +: CNT_W]     = hp;
    bus.burst_len[ch*BURST_W +: BURST_W]   = bl;
  endtask

  // Expected clk_out of a channel k cycles after its start edge.
  function automatic logic model_clk(int k, int h, int b);
    if (k >= 2*h*b) return 1'b0;
    return ((k / h) % 2) == 1;
  endfunction

  initial begin
    int k;
    int rises;
    int found;

    rst = 1'b1;
    bus.start = '0;
    bus.stop  = '0;
    bus.half_period = '0;
    bus.burst_len   = '0;

    // Reset.
    vecs.push_back(mk(1, 4'h0, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0));
    // ch0 burst hp=3 bl=2; start during RUN and in the done cycle ignored,
    // half_period changes while busy have no effect.
    vecs.push_back(mk(0, 4'h1, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd2, 4'h1, 4'h1, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 16'd3, 8'd2, 4'h1, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h1, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h1, 4'h1, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h1, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd7, 8'd9, 4'h1, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h0, 4'h1));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0));
    // ch1 free-run with hp=0 (treated as 1): stop while high, restart, stop while low.
    vecs.push_back(mk(0, 4'h2, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h2, 4'h2, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h2, 4'h2, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h2, 16'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h2));
    vecs.push_back(mk(0, 4'h2, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h2, 4'h2, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h2, 16'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h2));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));
    // start and stop together in IDLE: stays idle, no done.
    vecs.push_back(mk(0, 4'h2, 4'h2, 16'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));
    // ch0 free-run hp=3 aborted by reset while high: no done.
    vecs.push_back(mk(0, 4'h1, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd0, 4'h1, 4'h1, 4'h1, 4'h0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 16'd3, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop);
      bus.half_period = {NUM_CH{vecs[i].hp}};
      bus.burst_len   = {NUM_CH{vecs[i].bl}};
      step();
      chk("vec_clk_out", i, 32'(bus.clk_out),    32'(vecs[i].e_clk));
      chk("vec_rise",    i, 32'(bus.rise_pulse), 32'(vecs[i].e_rise));
      chk("vec_busy",    i, 32'(bus.busy),       32'(vecs[i].e_busy));
      chk("vec_done",    i, 32'(bus.done),       32'(vecs[i].e_done));
    end

    // ch0 hp=3 stop while high mid-phase: enters STOP, drains to the fall.
    set_ch(0, 16'd3, 8'd0);
    drive(0, 4'h1, 4'h0); step();
    drive(0, 4'h0, 4'h0); step(); step(); step();
    chk("stop_hi_rise", 0, 32'(bus.clk_out[0]), 32'd1);
    drive(0, 4'h0, 4'h1); step();
    chk("stop_hi_busy", 0, 32'({bus.busy[0], bus.clk_out[0], bus.done[0]}), 32'b110);
    drive(0, 4'h0, 4'h1); step();
    chk("stop_hi_hold", 0, 32'({bus.busy[0], bus.clk_out[0], bus.done[0]}), 32'b110);
    drive(0, 4'h0, 4'h0); step();
    chk("stop_hi_end", 0, 32'({bus.busy[0], bus.clk_out[0], bus.done[0]}), 32'b001);
    step();
    chk("stop_hi_idle", 0, 32'({bus.busy[0], bus.clk_out[0], bus.done[0]}), 32'b000);

    // ch0 hp=2 bl=2 and ch3 hp=5 bl=1 started in the same cycle.
    set_ch(0, 16'd2, 8'd2);
    set_ch(3, 16'd5, 8'd1);
    drive(0, 4'h9, 4'h0); step();
    drive(0, 4'h0, 4'h0);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("par_ch0_clk",  c, 32'(bus.clk_out[0]), 32'(model_clk(c, 2, 2)));
      chk("par_ch3_clk",  c, 32'(bus.clk_out[3]), 32'(model_clk(c, 5, 1)));
      chk("par_ch0_done", c, 32'(bus.done[0]),    32'(c == 8));
      chk("par_ch3_done", c, 32'(bus.done[3]),    32'(c == 10));
    end

    // ch2 burst 255 with hp=1: 255 rises then done at T+510.
    set_ch(2, 16'd1, 8'd255);
    drive(0, 4'h4, 4'h0); step();
    drive(0, 4'h0, 4'h0);
    rises = 0;
    found = 0;
    for (k = 1; k <= 600; k++) begin
      step();
      if (bus.rise_pulse[2]) rises++;
      if (bus.done[2]) begin
        found = k;
        break;
      end
    end
    chk("b255_done_at", 0, 32'(found), 32'd510);
    chk("b255_rises",   0, 32'(rises), 32'd255);
    chk("b255_busy",    0, 32'(bus.busy[2]), 32'd0);

    // ch2 hp=65535: first rise at T+65535, then reset aborts.
    set_ch(2, 16'hFFFF, 8'd1);
    drive(0, 4'h4, 4'h0); step();
    drive(0, 4'h0, 4'h0);
    found = 0;
    for (k = 1; k <= 66000; k++) begin
      step();
      if (bus.rise_pulse[2]) begin
        found = k;
        break;
      end
    end
    chk("hpmax_rise_at", 0, 32'(found), 32'd65535);
    chk("hpmax_clk",     0, 32'(bus.clk_out[2]), 32'd1);
    drive(1, 4'h0, 4'h0); step();
    chk("hpmax_rst", 0, 32'({bus.clk_out, bus.busy, bus.done, bus.rise_pulse}), 32'd0);
    drive(0, 4'h0, 4'h0); step();
    chk("hpmax_nodone", 0, 32'(bus.done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
